// File: rtl/mem_access_unit_pkg.sv
// Shared lc3b types for the memory-access stage: control-word fields and FSM state.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_indirect;
        logic mem_byte;
    } lc3b_control_word;

    typedef enum logic [1:0] {
        IDLE,
        ACC1,
        ACC2,
        DONE
    } lc3b_mem_state_t;

    function automatic lc3b_word sext8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Byte-lane handling: load lane select with sign extension, store replication, write enables.
module mem_byte_align
    import lc3b_types::*;
(
    input  logic       byte_mode,
    input  logic       byte_sel,
    input  logic       is_write,
    input  lc3b_word   rdata,
    input  lc3b_word   store_data,
    output lc3b_word   load_data,
    output lc3b_word   wdata,
    output logic [1:0] byte_enable
);

    always_comb begin
        load_data   = rdata;
        wdata       = store_data;
        byte_enable = 2'b11;
        if (byte_mode) begin
            load_data = byte_sel ? sext8(rdata[15:8]) : sext8(rdata[7:0]);
            if (is_write) begin
                wdata       = {store_data[7:0], store_data[7:0]};
                byte_enable = byte_sel ? 2'b10 : 2'b01;
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// lc3b MEM-stage access unit: one access for LDR/STR/LDB/STB, two for LDI/STI, stalling until done.
module mem_access_unit
    import lc3b_types::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  lc3b_control_word control_word,
    input  logic [15:0]      alu,
    input  logic [15:0]      mem_data,
    input  logic             byte_sel,
    input  logic             advance,
    input  logic [15:0]      dmem_rdata,
    input  logic             dmem_resp,
    output logic [15:0]      dmem_address,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [15:0]      dmem_wdata,
    output logic [1:0]       dmem_byte_enable,
    output logic             stall,
    output logic [15:0]      mem_result
);

    lc3b_mem_state_t state_q, state_d;
    lc3b_word        pointer_q, pointer_d;
    lc3b_word        result_q, result_d;
    lc3b_word        load_data;
    logic            mem_op;
    logic            byte_mode;

    assign mem_op     = control_word.mem_read | control_word.mem_write;
    assign byte_mode  = (state_q == ACC1) && control_word.mem_byte && !control_word.mem_indirect;
    assign mem_result = result_q;

    mem_byte_align u_align (
        .byte_mode   (byte_mode),
        .byte_sel    (byte_sel),
        .is_write    (control_word.mem_write),
        .rdata       (dmem_rdata),
        .store_data  (mem_data),
        .load_data   (load_data),
        .wdata       (dmem_wdata),
        .byte_enable (dmem_byte_enable)
    );

    always_comb begin
        state_d      = state_q;
        pointer_d    = pointer_q;
        result_d     = result_q;
        dmem_address = alu;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        stall        = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = mem_op;
                if (mem_op) state_d = ACC1;
            end
            ACC1: begin
                stall = 1'b1;
                if (control_word.mem_indirect) begin
                    dmem_read    = 1'b1;
                    dmem_address = {alu[15:1], 1'b0};
                    if (dmem_resp) begin
                        pointer_d = dmem_rdata;
                        state_d   = ACC2;
                    end
                end else begin
                    dmem_read    = control_word.mem_read;
                    dmem_write   = control_word.mem_write;
                    dmem_address = control_word.mem_byte ? alu : {alu[15:1], 1'b0};
                    if (dmem_resp) begin
                        if (control_word.mem_read) result_d = load_data;
                        state_d = DONE;
                    end
                end
            end
            ACC2: begin
                stall        = 1'b1;
                dmem_read    = control_word.mem_read;
                dmem_write   = control_word.mem_write;
                dmem_address = {pointer_q[15:1], 1'b0};
                if (dmem_resp) begin
                    if (control_word.mem_read) result_d = load_data;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Hold here until the MEM register moves on so a held store is not replayed.
                if (advance) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pointer_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            pointer_q <= pointer_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with an inline memory responder of programmable latency.
module tb_mem_access_unit;
    import lc3b_types::*;

    localparam lc3b_control_word NOP = 4'b0000;
    localparam lc3b_control_word LDR = 4'b1000;
    localparam lc3b_control_word LDB = 4'b1001;
    localparam lc3b_control_word STB = 4'b0101;
    localparam lc3b_control_word LDI = 4'b1010;
    localparam lc3b_control_word STI = 4'b0110;

    logic             clk = 1'b0;
    logic             reset_n;
    lc3b_control_word control_word;
    logic [15:0]      alu, mem_data, dmem_rdata;
    logic             byte_sel, advance, dmem_resp;
    logic [15:0]      dmem_address, dmem_wdata, mem_result;
    logic             dmem_read, dmem_write, stall;
    logic [1:0]       dmem_byte_enable;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    int unsigned stall_cnt, nreq;
    logic        unstable, idle_req, op_done;
    logic [15:0] addr_r [2];
    logic [15:0] wd_r   [2];
    logic        wr_r   [2];
    logic [1:0]  be_r   [2];
    logic        extra;

    mem_access_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .control_word     (control_word),
        .alu              (alu),
        .mem_data         (mem_data),
        .byte_sel         (byte_sel),
        .advance          (advance),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .dmem_address     (dmem_address),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .stall            (stall),
        .mem_result       (mem_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Starts 1ns after an edge in IDLE; returns 2ns after the edge that entered DONE.
    task automatic run_op(input lc3b_control_word c, input logic [15:0] a, input logic [15:0] d,
                          input logic bs, input int unsigned lat0, input int unsigned lat1,
                          input logic [15:0] rd0, input logic [15:0] rd1);
        int unsigned cnt;
        int unsigned lat;
        control_word = c;
        alu          = a;
        mem_data     = d;
        byte_sel     = bs;
        advance      = 1'b0;
        dmem_resp    = 1'b0;
        stall_cnt    = 0;
        nreq         = 0;
        unstable     = 1'b0;
        idle_req     = 1'b0;
        op_done      = 1'b0;
        cnt          = 0;
        for (int unsigned i = 0; i < 60 && !op_done; i++) begin
            #1;
            if (!stall) begin
                op_done = 1'b1;
            end else begin
                stall_cnt++;
                if (i == 0) idle_req = dmem_read | dmem_write;
                if (dmem_read | dmem_write) begin
                    if (nreq > 1) begin
                        unstable = 1'b1;
                    end else if (cnt == 0) begin
                        addr_r[nreq] = dmem_address;
                        wd_r[nreq]   = dmem_wdata;
                        wr_r[nreq]   = dmem_write;
                        be_r[nreq]   = dmem_byte_enable;
                    end else if (addr_r[nreq] !== dmem_address || wr_r[nreq] !== dmem_write ||
                                 wd_r[nreq] !== dmem_wdata || be_r[nreq] !== dmem_byte_enable) begin
                        unstable = 1'b1;
                    end
                    cnt++;
                    lat = (nreq == 0) ? lat0 : lat1;
                    if (cnt >= lat) begin
                        dmem_resp  = 1'b1;
                        dmem_rdata = (nreq == 0) ? rd0 : rd1;
                        nreq++;
                        cnt = 0;
                    end
                end
                cyc();
                dmem_resp  = 1'b0;
                dmem_rdata = 16'hDEAD;
            end
        end
        check("op_reaches_done", {15'd0, op_done}, 16'd1);
        check("no_request_in_idle", {15'd0, idle_req}, 16'd0);
        check("request_stable", {15'd0, unstable}, 16'd0);
        check("done_no_request", {14'd0, dmem_read, dmem_write}, 16'd0);
    endtask

    task automatic release_op();
        advance = 1'b1;
        cyc();
        advance      = 1'b0;
        control_word = NOP;
    endtask

    initial begin
        reset_n      = 1'b0;
        control_word = NOP;
        alu          = 16'h0000;
        mem_data     = 16'h0000;
        byte_sel     = 1'b0;
        advance      = 1'b0;
        dmem_rdata   = 16'h0000;
        dmem_resp    = 1'b0;
        #12;
        check("reset_stall", {15'd0, stall}, 16'd0);
        check("reset_req", {14'd0, dmem_read, dmem_write}, 16'd0);
        check("reset_result", mem_result, 16'h0000);
        reset_n  = 1'b1;
        mem_data = 16'h7A5C;
        cyc();
        check("idle_be", {14'd0, dmem_byte_enable}, 16'h0003);
        check("idle_wdata", dmem_wdata, 16'h7A5C);

        // LDR, R = 2
        run_op(LDR, 16'h3005, 16'h0000, 1'b0, 2, 0, 16'hBEEF, 16'h0000);
        check("ldr_stall_cycles", stall_cnt[15:0], 16'd3);
        check("ldr_addr", addr_r[0], 16'h3004);
        check("ldr_nreq", nreq[15:0], 16'd1);
        check("ldr_is_read", {15'd0, wr_r[0]}, 16'd0);
        check("ldr_result", mem_result, 16'hBEEF);
        release_op();

        // LDB high lane, back-to-back start checks the IDLE bubble
        run_op(LDB, 16'h2001, 16'h0000, 1'b1, 1, 0, 16'h80FF, 16'h0000);
        check("ldb_hi_stall_cycles", stall_cnt[15:0], 16'd2);
        check("ldb_hi_addr", addr_r[0], 16'h2001);
        check("ldb_hi_result", mem_result, 16'hFF80);
        release_op();

        run_op(LDB, 16'h2000, 16'h0000, 1'b0, 1, 0, 16'h80FF, 16'h0000);
        check("ldb_lo_result", mem_result, 16'hFFFF);
        release_op();

        // STB low lane, R = 3
        run_op(STB, 16'h3007, 16'h12AB, 1'b0, 3, 0, 16'h0000, 16'h0000);
        check("stb_stall_cycles", stall_cnt[15:0], 16'd4);
        check("stb_addr", addr_r[0], 16'h3007);
        check("stb_is_write", {15'd0, wr_r[0]}, 16'd1);
        check("stb_wdata", wd_r[0], 16'hABAB);
        check("stb_be", {14'd0, be_r[0]}, 16'h0001);
        check("stb_result_kept", mem_result, 16'hFFFF);
        release_op();

        // LDI, R1 = 2, R2 = 1
        run_op(LDI, 16'h4000, 16'h0000, 1'b0, 2, 1, 16'h5000, 16'h0042);
        check("ldi_stall_cycles", stall_cnt[15:0], 16'd4);
        check("ldi_nreq", nreq[15:0], 16'd2);
        check("ldi_addr1", addr_r[0], 16'h4000);
        check("ldi_addr2", addr_r[1], 16'h5000);
        check("ldi_result", mem_result, 16'h0042);
        release_op();

        // STI, R1 = 1, R2 = 2, then MEM register held for 3 cycles
        run_op(STI, 16'h4001, 16'h1234, 1'b0, 1, 2, 16'h6001, 16'h0000);
        check("sti_stall_cycles", stall_cnt[15:0], 16'd4);
        check("sti_nreq", nreq[15:0], 16'd2);
        check("sti_addr1", addr_r[0], 16'h4000);
        check("sti_first_is_read", {15'd0, wr_r[0]}, 16'd0);
        check("sti_addr2", addr_r[1], 16'h6000);
        check("sti_second_is_write", {15'd0, wr_r[1]}, 16'd1);
        check("sti_wdata", wd_r[1], 16'h1234);
        check("sti_be", {14'd0, be_r[1]}, 16'h0003);
        extra = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            extra = extra | stall | dmem_read | dmem_write;
        end
        check("sti_held_no_reissue", {15'd0, extra}, 16'd0);
        check("sti_result_kept", mem_result, 16'h0042);
        release_op();

        // Non-memory instruction adds no stall
        control_word = NOP;
        #1;
        check("nop_stall", {15'd0, stall}, 16'd0);
        cyc();
        check("nop_stall_next", {14'd0, stall, dmem_read | dmem_write}, 16'd0);

        // Reset asserted during ACC2 of an STI
        control_word = STI;
        alu          = 16'h4100;
        mem_data     = 16'h5555;
        cyc();
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h7000;
        #1;
        check("rst_acc1_read", {15'd0, dmem_read}, 16'd1);
        check("rst_acc1_addr", dmem_address, 16'h4100);
        cyc();
        dmem_resp = 1'b0;
        #1;
        check("rst_acc2_write", {15'd0, dmem_write}, 16'd1);
        check("rst_acc2_addr", dmem_address, 16'h7000);
        reset_n = 1'b0;
        #1;
        check("rst_write_drops", {14'd0, dmem_read, dmem_write}, 16'd0);
        check("rst_idle_stall_op", {15'd0, stall}, 16'd1);
        check("rst_result_cleared", mem_result, 16'h0000);
        control_word = NOP;
        #1;
        check("rst_idle_stall_nop", {15'd0, stall}, 16'd0);
        cyc();
        reset_n    = 1'b1;
        dmem_resp  = 1'b1;
        dmem_rdata = 16'hBBBB;
        cyc();
        dmem_resp = 1'b0;
        #1;
        check("stray_resp_result", mem_result, 16'h0000);
        check("stray_resp_outputs", {13'd0, stall, dmem_read, dmem_write}, 16'd0);
        cyc();
        check("stray_resp_settled", {13'd0, stall, dmem_read, dmem_write}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the lc3b pipeline, sitting directly downstream of the MEM stage register and upstream of the writeback stage register. It turns the latched control word, ALU address and store data into a request/response transaction on the data-memory port: a single access for LDR/STR/LDB/STB, two back-to-back accesses for LDI/STI. It stalls the pipeline until the access completes and presents the loaded/extended result to writeback.

## Interface
Parameters: none (widths come from lc3b_types).
- clk  in  1  pipeline clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- control_word  in  lc3b_control_word  from MEM stage register; uses fields mem_read, mem_write, mem_indirect, mem_byte
- alu  in  16  effective address
- mem_data  in  16  store data (SR value)
- byte_sel  in  1  byte lane for LDB/STB: 0 = low byte, 1 = high byte
- advance  in  1  global pipeline load; 1 = MEM stage register captures its next instruction this edge
- dmem_rdata  in  16  data-memory read data
- dmem_resp  in  1  data-memory completion strobe, valid for one cycle
- dmem_address  out  16  memory address
- dmem_read  out  1  read request, held until dmem_resp
- dmem_write  out  1  write request, held until dmem_resp
- dmem_wdata  out  16  write data
- dmem_byte_enable  out  2  write lanes: [1] high, [0] low
- stall  out  1  1 = hold all upstream stages
- mem_result  out  16  loaded value for writeback

## Operation
- A memory op is a control word with mem_read or mem_write set. mem_indirect qualifies either one.
- FSM states are IDLE, ACC1, ACC2 and DONE.
- IDLE: stall = 1 if a memory op is present, else 0. No request is driven. A memory op moves to ACC1.
- ACC1: dmem_address = alu.
  - Indirect: dmem_read = 1 and is word-sized. On dmem_resp, latch dmem_rdata into the pointer register and go to ACC2.
  - Otherwise: dmem_read = mem_read and dmem_write = mem_write. On dmem_resp, latch the result and go to DONE.
  - stall = 1 throughout.
- ACC2: dmem_address = pointer. Read (LDI) or write (STI) of mem_data, word-sized. On dmem_resp, latch the result and go to DONE. stall = 1.
- DONE: stall = 0 and mem_result is valid. Go to IDLE on the edge where advance = 1; otherwise stay in DONE. This prevents re-executing a store while an external stall holds the MEM register.
- Word access:
  - dmem_address[0] forced to 0.
  - dmem_byte_enable = 2'b11.
  - mem_result = dmem_rdata.
- Byte load: mem_result = sign-extended dmem_rdata[15:8] if byte_sel = 1, else sign-extended dmem_rdata[7:0].
- Byte store:
  - dmem_wdata = {mem_data[7:0], mem_data[7:0]}.
  - dmem_byte_enable = 2'b10 if byte_sel = 1, else 2'b01.
  - dmem_address is alu unmodified.
- Stores leave mem_result unchanged. mem_result only changes on a load/indirect-load completion.
- Idle outputs: dmem_read = dmem_write = 0, dmem_wdata = mem_data, dmem_byte_enable = 2'b11.

## Timing
- Reset (asynchronous, any state):
  - state = IDLE, pointer = 0, mem_result = 0.
  - dmem_read = dmem_write = 0.
  - stall = 0 if no memory op is present.
  - A transaction cut off mid-flight is abandoned; a late dmem_resp in IDLE is ignored.
- Single access with response latency R (cycles after the request is raised, R ≥ 1): stall is high for 1 + R cycles, then DONE.
- Indirect access: stall is high for 1 + R1 + R2 cycles.
- Request signals are a pure function of state and the registered inputs. They stay stable and continuously asserted until the resp cycle and drop the cycle after it.
- dmem_resp outside ACC1/ACC2 is ignored.
- Non-memory instruction: stall = 0 and no state change, i.e. zero added latency.
- Back-to-back memory ops: DONE → IDLE (new op seen) → ACC1. One bubble cycle between transactions is required behaviour.

## Structure
- lc3b_types gains the control-word fields mem_read, mem_write, mem_indirect and mem_byte, and the enum lc3b_mem_state_t {IDLE, ACC1, ACC2, DONE}.
- One combinational sub-module, mem_byte_align, handles lane select, sign extension, store-data replication and byte enables. FSM, pointer register and result register stay in the top.

## Test plan
- LDR, alu = 0x3005, rdata 0xBEEF, R = 2:
  - dmem_address = 0x3004 and stall high for 3 cycles.
  - mem_result = 0xBEEF in DONE.
- LDB, byte_sel = 1, rdata 0x80FF: mem_result = 0xFF80. With byte_sel = 0: mem_result = 0xFFFF.
- STB, byte_sel = 0, mem_data = 0x12AB: dmem_wdata = 0xABAB, byte_enable = 2'b01, dmem_write held until resp; mem_result unchanged.
- LDI, alu = 0x4000:
  - First read returns 0x5000; second read at 0x5000 returns 0x0042.
  - mem_result = 0x0042.
  - Stall covers 1 + R1 + R2 cycles.
- STI with advance = 0 for 3 cycles after DONE: exactly two memory transactions occur, stall = 0 throughout DONE, and there is no re-issue.
- reset_n pulsed low during an ACC2 of an STI:
  - dmem_write drops immediately and state = IDLE.
  - A subsequent stray dmem_resp causes no output change.
